// File: rtl/lcd_reader.sv
`default_nettype none
// ============================================================================
//  Module      : lcd_reader
//  Description : Performs HD44780-style read cycles (status/busy-flag or data)
//                on a character LCD in response to a one-cycle CPU read strobe
//                at BASEADDRESS+2 (status) or BASEADDRESS+3 (data). Generates
//                RS/RW setup, a timed EN pulse, captures the LCD bus on the
//                falling edge of EN and returns the byte zero-extended.
//  Ports       : ACLK, RESET        - clock, synchronous active-high reset
//                ADDR, RDSTB        - CPU byte address and read strobe
//                DATA_O, VALID      - read result and its one-cycle valid pulse
//                BUSY               - high while a read cycle is in progress
//                LCD_DATA_I         - LCD data bus input
//                LCD_DATA_OE        - LCD bus output enable (always released)
//                LCD_EN/RS/RW       - LCD control strobes
//  Revision    : 1.0 - initial release
// ============================================================================
module lcd_reader #(
    parameter logic [31:0] BASEADDRESS = 32'h5000_0000,
    parameter int          SETUP_CYC   = 3,
    parameter int          PULSE_CYC   = 25,
    parameter int          HOLD_CYC    = 3
) (
    input  logic        ACLK,
    input  logic        RESET,
    input  logic [31:0] ADDR,
    input  logic        RDSTB,
    output logic [31:0] DATA_O,
    output logic        VALID,
    output logic        BUSY,
    input  logic [7:0]  LCD_DATA_I,
    output logic        LCD_DATA_OE,
    output logic        LCD_EN,
    output logic        LCD_RS,
    output logic        LCD_RW
);

    localparam logic [31:0] c_status_addr = BASEADDRESS + 32'd2;
    localparam logic [31:0] c_data_addr   = BASEADDRESS + 32'd3;

    localparam int c_max_sp  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int c_max_cyc = (c_max_sp > HOLD_CYC) ? c_max_sp : HOLD_CYC;
    localparam int c_cnt_w   = (c_max_cyc > 1) ? $clog2(c_max_cyc) : 1;

    localparam logic [c_cnt_w-1:0] c_setup_ld = c_cnt_w'(SETUP_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_pulse_ld = c_cnt_w'(PULSE_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_hold_ld  = c_cnt_w'(HOLD_CYC - 1);
    localparam logic [c_cnt_w-1:0] c_one      = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SETUP = 2'd1,
        S_PULSE = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic [c_cnt_w-1:0] r_count;
    logic [7:0]         r_byte;
    logic               w_hit;

    assign w_hit       = RDSTB && ((ADDR == c_status_addr) || (ADDR == c_data_addr));
    assign BUSY        = (r_state != S_IDLE);
    assign LCD_DATA_OE = 1'b0;

    always_ff @(posedge ACLK) begin
        if (RESET) begin
            r_state <= S_IDLE;
            r_count <= '0;
            r_byte  <= '0;
            DATA_O  <= '0;
            VALID   <= 1'b0;
            LCD_EN  <= 1'b0;
            LCD_RS  <= 1'b0;
            LCD_RW  <= 1'b0;
        end else begin
            VALID <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_hit) begin
                        LCD_RS  <= ADDR[0];
                        LCD_RW  <= 1'b1;
                        r_count <= c_setup_ld;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_count == '0) begin
                        LCD_EN  <= 1'b1;
                        r_count <= c_pulse_ld;
                        r_state <= S_PULSE;
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end
                S_PULSE: begin
                    if (r_count == '0) begin
                        // Bus is sampled on the same edge EN falls.
                        LCD_EN  <= 1'b0;
                        r_byte  <= LCD_DATA_I;
                        r_count <= c_hold_ld;
                        r_state <= S_HOLD;
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end
                S_HOLD: begin
                    if (r_count == '0) begin
                        DATA_O <= {24'b0, r_byte};
                        VALID  <= 1'b1;
                        // The completion edge doubles as the return to idle, so a
                        // request present here starts the next read immediately
                        // and RW stays asserted across back-to-back reads.
                        if (w_hit) begin
                            LCD_RS  <= ADDR[0];
                            LCD_RW  <= 1'b1;
                            r_count <= c_setup_ld;
                            r_state <= S_SETUP;
                        end else begin
                            LCD_RW  <= 1'b0;
                            r_state <= S_IDLE;
                        end
                    end else begin
                        r_count <= r_count - c_one;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: doc/lcd_reader.md
LCD_READER -- requirements
Module: lcd_reader

Interface
REQ-001 SHALL have parameter BASEADDRESS, default 32'h5000_0000, the LCD peripheral base address; the read registers sit at BASEADDRESS+2 (status) and BASEADDRESS+3 (data).
REQ-002 SHALL have parameter SETUP_CYC, default 3, the ACLK cycles from RS/RW valid to the rising edge of LCD_EN (minimum 1).
REQ-003 SHALL have parameter PULSE_CYC, default 25, the ACLK cycles LCD_EN is held high (500 ns at 50 MHz; minimum 1).
REQ-004 SHALL have parameter HOLD_CYC, default 3, the ACLK cycles from the falling edge of LCD_EN to completion (minimum 1).
REQ-005 SHALL have port ACLK, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-006 SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-007 SHALL have port ADDR, input, 32 bits: CPU byte address.
REQ-008 SHALL have port RDSTB, input, 1 bit: CPU read strobe, one cycle.
REQ-009 SHALL have port DATA_O, output, 32 bits: the read result, {24'b0, captured byte}.
REQ-010 SHALL have port VALID, output, 1 bit: one-cycle pulse when DATA_O is updated.
REQ-011 SHALL have port BUSY, output, 1 bit: high while a read cycle is in progress.
REQ-012 SHALL have port LCD_DATA_I, input, 8 bits: the LCD data bus as seen by this block.
REQ-013 SHALL have port LCD_DATA_OE, output, 1 bit: constant 0; tells the top level to release the LCD bus during reads.
REQ-014 SHALL have port LCD_EN, output, 1 bit: LCD enable strobe.
REQ-015 SHALL have port LCD_RS, output, 1 bit: 0 = status/busy-flag read, 1 = data read.
REQ-016 SHALL have port LCD_RW, output, 1 bit: 1 while a read cycle is in progress, else 0.

Function
REQ-017 SHALL implement the state machine IDLE -> SETUP -> PULSE -> HOLD -> IDLE, with a down-counter wide enough for the largest of SETUP_CYC, PULSE_CYC and HOLD_CYC.
REQ-018 SHALL accept a request only in IDLE, and only when RDSTB=1 and ADDR equals BASEADDRESS+2 or BASEADDRESS+3, using a full 32-bit compare.
REQ-019 On the acceptance edge (edge 0), SHALL register LCD_RS<=ADDR[0], LCD_RW<=1 and counter<=SETUP_CYC-1, and go to SETUP.
REQ-020 In SETUP, when counter==0, SHALL set LCD_EN<=1 and counter<=PULSE_CYC-1 and go to PULSE; otherwise it SHALL decrement the counter.
REQ-021 In PULSE, when counter==0, SHALL set LCD_EN<=0, capture LCD_DATA_I into the data register on that same edge, set counter<=HOLD_CYC-1 and go to HOLD.
REQ-022 In HOLD, when counter==0, SHALL drive DATA_O<={24'b0, captured byte}, pulse VALID for exactly one cycle, set LCD_RW<=0 and go to IDLE.
REQ-023 Cycle-level timing SHALL be: LCD_EN rises at edge SETUP_CYC, falls at edge SETUP_CYC+PULSE_CYC, and VALID asserts at edge SETUP_CYC+PULSE_CYC+HOLD_CYC (defaults: 3, 28, 31).
REQ-024 BUSY SHALL equal (state != IDLE); it is high from edge 0 until the edge on which VALID asserts.
REQ-025 RDSTB received while BUSY=1 SHALL be ignored, with no queuing and no error indication.
REQ-026 RDSTB to any other address SHALL be ignored; LCD outputs and DATA_O stay unchanged.
REQ-027 DATA_O SHALL hold its last value between reads; VALID SHALL be 0 outside the completion cycle.
REQ-028 LCD_RS SHALL hold its last value while in IDLE.
REQ-029 LCD_DATA_OE SHALL be 0 in every state.
REQ-030 A request arriving on the same cycle the block returns to IDLE (the VALID cycle) SHALL be accepted, giving back-to-back reads.

Reset
REQ-031 On RESET=1 at a rising ACLK edge, SHALL set: state=IDLE, counter=0, LCD_EN=0, LCD_RS=0, LCD_RW=0, DATA_O=0, VALID=0, BUSY=0.
REQ-032 RESET SHALL take priority over every other input, including a reset asserted mid-cycle in PULSE: LCD_EN drops on the next edge, no VALID is produced and DATA_O returns to 0.

Verification
REQ-033 Status read: RDSTB at ADDR=32'h5000_0002 with LCD_DATA_I=8'h80 -> LCD_RS=0, LCD_RW=1; LCD_EN high from edge 3 to edge 28; VALID at edge 31 with DATA_O=32'h0000_0080; BUSY low from edge 31.
REQ-034 Data read: RDSTB at ADDR=32'h5000_0003 with LCD_DATA_I=8'h41 -> LCD_RS=1 and DATA_O=32'h0000_0041 with a single VALID pulse.
REQ-035 Ignored requests: RDSTB at 32'h5000_0000, 32'h5000_0001 and 32'h5000_0004, plus a second RDSTB at edge 10 of an active read -> no state change, exactly one VALID pulse total.
REQ-036 Capture point: LCD_DATA_I changes from 8'h11 to 8'h22 one cycle before LCD_EN falls, then to 8'h33 after it falls -> DATA_O=32'h0000_0022.
REQ-037 Reset mid-operation: RESET asserted at edge 15 -> all outputs at reset values on the next edge; a following status read completes normally.
REQ-038 Back-to-back: RDSTB held high continuously at 32'h5000_0003 -> VALID at edges 31 and 62, LCD_RW never drops between the two reads except on the VALID cycle.
